// File: rtl/mem_stage.sv
// mem_stage: RV32I data-memory stage. Takes one EX result per handshake, runs
// LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack port (with ack timeout), and
// presents registered write-back data to WB.
// Ports: i_clk/i_reset (sync, active-low); EX side i_valid + operands,
// o_stall back to EX; dmem side o_dmem_req/we/addr/wdata/be, i_dmem_ack/rdata;
// WB side o_valid pulse, o_wb_data/o_rd/o_reg_write, o_misaligned/o_bus_err.
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_ALUOutput,
  input  logic [31:0] i_store_data,
  input  logic [2:0]  i_func3,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [4:0]  i_rd,
  input  logic        i_reg_write,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  // Abort fires on the edge that ends the ACK_TIMEOUT-th unacknowledged cycle.
  localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [31:0] addr_q;   // full byte address of the outstanding access
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        load_q;

  logic        is_mem, is_load, f3_legal, misal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        accept, ack_done, abort;

  assign o_stall     = (state == ACCESS);
  assign o_dmem_addr = {addr_q[31:2], 2'b00};

  // Decode of the incoming EX result. Read+write together is treated as a load.
  always_comb begin
    is_mem  = i_mem_read | i_mem_write;
    is_load = i_mem_read;
    if (is_load) f3_legal = (i_func3 != 3'b011) && (i_func3[2:1] != 2'b11);
    else         f3_legal = !i_func3[2] && (i_func3[1:0] != 2'b11);
    case (i_func3[1:0])
      2'b01:   misal = i_ALUOutput[0];
      2'b10:   misal = |i_ALUOutput[1:0];
      default: misal = 1'b0;
    endcase
    case (i_func3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << i_ALUOutput[1:0];
        st_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        st_be    = i_ALUOutput[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = i_store_data;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned read word.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = i_dmem_rdata[7:0];
      2'b01:   ld_byte = i_dmem_rdata[15:8];
      2'b10:   ld_byte = i_dmem_rdata[23:16];
      default: ld_byte = i_dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{!f3_q[2] && ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{!f3_q[2] && ld_half[15]}}, ld_half};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  // Next state. Ack is checked before the timeout so a same-cycle ack wins.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ack_done  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          accept = 1'b1;
          if (is_mem && f3_legal && !misal) state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (i_dmem_ack) begin
          ack_done  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      f3_q         <= '0;
      rd_q         <= '0;
      load_q       <= 1'b0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_wdata <= '0;
      o_dmem_be    <= '0;
      o_valid      <= 1'b0;
      o_wb_data    <= '0;
      o_rd         <= '0;
      o_reg_write  <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;

      if (accept) begin
        if (!is_mem || !f3_legal || misal) begin
          // Completes in one cycle; faults report the address as wb data.
          o_valid      <= 1'b1;
          o_wb_data    <= i_ALUOutput;
          o_rd         <= i_rd;
          o_reg_write  <= !is_mem && i_reg_write && (i_rd != 5'd0);
          o_bus_err    <= is_mem && !f3_legal;
          o_misaligned <= is_mem && f3_legal && misal;
        end else begin
          o_dmem_req   <= 1'b1;
          o_dmem_we    <= !is_load;
          o_dmem_be    <= is_load ? 4'b1111 : st_be;
          o_dmem_wdata <= is_load ? '0 : st_wdata;
          addr_q       <= i_ALUOutput;
          f3_q         <= i_func3;
          rd_q         <= i_rd;
          load_q       <= is_load;
          cnt          <= '0;
        end
      end

      if (ack_done) begin
        o_dmem_req  <= 1'b0;
        o_valid     <= 1'b1;
        o_rd        <= rd_q;
        o_reg_write <= load_q && (rd_q != 5'd0);
        if (load_q) o_wb_data <= ld_data;
      end else if (abort) begin
        o_dmem_req  <= 1'b0;
        o_valid     <= 1'b1;
        o_bus_err   <= 1'b1;
        o_rd        <= rd_q;
        o_reg_write <= 1'b0;
        o_wb_data   <= addr_q;
      end else if (state == ACCESS) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// behavioural model of the RV32I load/store rules (ACK_TIMEOUT = 4).
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_ALUOutput;
  logic [31:0] i_store_data;
  logic [2:0]  i_func3;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [4:0]  i_rd;
  logic        i_reg_write;
  logic        o_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_valid;
  logic [31:0] o_wb_data;
  logic [4:0]  o_rd;
  logic        o_reg_write;
  logic        o_misaligned;
  logic        o_bus_err;

  int n_assert = 0;
  int n_fail   = 0;

  mem_stage #(.ACK_TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid),
    .i_ALUOutput(i_ALUOutput), .i_store_data(i_store_data), .i_func3(i_func3),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_rd(i_rd),
    .i_reg_write(i_reg_write), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_valid(o_valid), .o_wb_data(o_wb_data), .o_rd(o_rd),
    .o_reg_write(o_reg_write), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] f3,
                       input logic r, input logic w, input logic [4:0] rd, input logic rw);
    i_valid      = 1'b1;
    i_ALUOutput  = addr;
    i_store_data = sd;
    i_func3      = f3;
    i_mem_read   = r;
    i_mem_write  = w;
    i_rd         = rd;
    i_reg_write  = rw;
  endtask

  // Issue one instruction and check it to completion against the model.
  // waitc = cycles of req before the ack cycle (ack arrives in cycle waitc+1).
  task automatic do_op(input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] f3,
                       input logic r, input logic w, input logic [4:0] rd, input logic rw,
                       input int waitc, input logic [31:0] rdata, input string tag);
    bit          is_mem;
    bit          legal;
    bit          mis;
    int          nb;
    int          ofs;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] lane;
    longint      v;
    logic [31:0] exp_ld;
    is_mem = r || w;
    nb     = 1 << f3[1:0];
    ofs    = int'(addr % 4);
    legal  = r ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    mis    = (addr % nb) != 0;
    exp_be = 4'(((1 << nb) - 1) << ofs);
    if (nb == 1)      exp_wd = (sd & 32'hFF) * 32'h0101_0101;
    else if (nb == 2) exp_wd = (sd & 32'hFFFF) * 32'h0001_0001;
    else              exp_wd = sd;
    lane = rdata >> (8 * ofs);
    if (nb == 4) v = longint'(rdata);
    else begin
      v = longint'(lane) % (longint'(1) << (8 * nb));
      if (!f3[2] && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    end
    exp_ld = v[31:0];

    chk({tag, " ready"}, o_stall, 1'b0);
    drive(addr, sd, f3, r, w, rd, rw);
    tick();
    i_valid = 1'b0;
    if (!is_mem || !legal || mis) begin
      chk({tag, " valid"}, o_valid, 1'b1);
      chk({tag, " req"}, o_dmem_req, 1'b0);
      chk({tag, " bus_err"}, o_bus_err, is_mem && !legal);
      chk({tag, " misaligned"}, o_misaligned, is_mem && legal && mis);
      chk({tag, " reg_write"}, o_reg_write, !is_mem && rw && (rd != 0));
      chk({tag, " rd"}, o_rd, rd);
      if (!is_mem || (legal && mis)) chk({tag, " wb_data"}, o_wb_data, addr);
    end else begin
      for (int k = 0; k <= waitc; k++) begin
        chk({tag, " req"}, o_dmem_req, 1'b1);
        chk({tag, " stall"}, o_stall, 1'b1);
        chk({tag, " addr"}, o_dmem_addr, addr & 32'hFFFF_FFFC);
        chk({tag, " we"}, o_dmem_we, !r);
        chk({tag, " be"}, o_dmem_be, r ? 4'hF : exp_be);
        if (!r) chk({tag, " wdata"}, o_dmem_wdata, exp_wd);
        chk({tag, " no early valid"}, o_valid, 1'b0);
        i_dmem_rdata = (k == waitc) ? rdata : $urandom;
        i_dmem_ack   = (k == waitc);
        tick();
      end
      i_dmem_ack = 1'b0;
      chk({tag, " valid"}, o_valid, 1'b1);
      chk({tag, " stall after"}, o_stall, 1'b0);
      chk({tag, " req after"}, o_dmem_req, 1'b0);
      chk({tag, " bus_err"}, o_bus_err, 1'b0);
      chk({tag, " rd"}, o_rd, rd);
      chk({tag, " reg_write"}, o_reg_write, r && (rd != 0));
      if (r) chk({tag, " load data"}, o_wb_data, exp_ld);
    end
    tick();
    chk({tag, " valid pulse"}, o_valid, 1'b0);
    chk({tag, " flags pulse"}, {o_bus_err, o_misaligned}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sd;
    i_reset = 1'b0;
    i_dmem_ack = 1'b0;
    i_dmem_rdata = 32'h0;
    drive(32'hA5A5_5A5A, 32'h1234_5678, 3'd2, 1'b1, 1'b0, 5'd3, 1'b1);
    repeat (3) tick();
    chk("rst stall", o_stall, 1'b0);
    chk("rst req", o_dmem_req, 1'b0);
    chk("rst we", o_dmem_we, 1'b0);
    chk("rst addr", o_dmem_addr, 32'h0);
    chk("rst wdata", o_dmem_wdata, 32'h0);
    chk("rst be", o_dmem_be, 4'h0);
    chk("rst valid", o_valid, 1'b0);
    chk("rst wb_data", o_wb_data, 32'h0);
    chk("rst rd", o_rd, 5'd0);
    chk("rst reg_write", o_reg_write, 1'b0);
    chk("rst flags", {o_misaligned, o_bus_err}, 2'b00);
    i_valid = 1'b0;
    i_reset = 1'b1;
    tick();

    do_op(32'h0000_1234, 32'h0, 3'd0, 1'b0, 1'b0, 5'd5, 1'b1, 0, 32'h0, "alu");
    chk("alu wb hold", o_wb_data, 32'h0000_1234);
    do_op(32'h0000_0777, 32'h0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1, 0, 32'h0, "alu x0");

    do_op(32'h0000_1003, 32'h0, 3'd0, 1'b1, 1'b0, 5'd7, 1'b1, 2, 32'h80FF_0011, "LB");
    chk("LB value", o_wb_data, 32'hFFFF_FF80);
    do_op(32'h0000_1003, 32'h0, 3'd4, 1'b1, 1'b0, 5'd7, 1'b1, 2, 32'h80FF_0011, "LBU");
    chk("LBU value", o_wb_data, 32'h0000_0080);
    do_op(32'h0000_2002, 32'hDEAD_BEEF, 3'd1, 1'b0, 1'b1, 5'd0, 1'b0, 1, 32'h0, "SH");
    chk("SH keeps wb", o_wb_data, 32'h0000_0080);
    do_op(32'h0000_3001, 32'h0, 3'd2, 1'b1, 1'b0, 5'd9, 1'b1, 0, 32'h0, "LW mis");
    do_op(32'h0000_3000, 32'h0, 3'd3, 1'b1, 1'b0, 5'd9, 1'b1, 0, 32'h0, "ld f3=3");
    do_op(32'h0000_3001, 32'h0, 3'd6, 1'b1, 1'b0, 5'd9, 1'b1, 0, 32'h0, "mis+badf3");
    do_op(32'h0000_6006, 32'h0, 3'd5, 1'b1, 1'b1, 5'd4, 1'b1, 3, 32'h8123_4567, "rd+wr LHU");

    // Timeout: req held for exactly 4 cycles, then a bus error pulse.
    drive(32'h0000_4000, 32'h0, 3'd2, 1'b1, 1'b0, 5'd9, 1'b1);
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("to req held", o_dmem_req, 1'b1);
      chk("to stall", o_stall, 1'b1);
      tick();
    end
    chk("to req dropped", o_dmem_req, 1'b0);
    chk("to valid", o_valid, 1'b1);
    chk("to bus_err", o_bus_err, 1'b1);
    chk("to reg_write", o_reg_write, 1'b0);
    chk("to stall off", o_stall, 1'b0);
    i_dmem_ack = 1'b1;
    tick();
    i_dmem_ack = 1'b0;
    chk("late ack valid", o_valid, 1'b0);
    chk("late ack req", o_dmem_req, 1'b0);
    do_op(32'h0000_0042, 32'h0, 3'd1, 1'b0, 1'b0, 5'd12, 1'b1, 0, 32'h0, "after to");

    // Reset in the middle of a store access.
    sd = $urandom;
    drive(32'h0000_5004, sd, 3'd2, 1'b0, 1'b1, 5'd0, 1'b0);
    tick();
    i_valid = 1'b0;
    chk("rsta req", o_dmem_req, 1'b1);
    i_reset = 1'b0;
    tick();
    chk("rsta req off", o_dmem_req, 1'b0);
    chk("rsta stall", o_stall, 1'b0);
    i_reset = 1'b1;
    i_dmem_ack = 1'b1;
    tick();
    i_dmem_ack = 1'b0;
    chk("rsta ack ignored", o_valid, 1'b0);
    chk("rsta idle", o_stall, 1'b0);
    do_op(32'h0000_0099, 32'h0, 3'd0, 1'b0, 1'b0, 5'd31, 1'b1, 0, 32'h0, "after rsta");

    // Randomized mix.
    for (int n = 0; n < 120; n++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      logic        r;
      logic        w;
      a  = $urandom;
      f3 = 3'($urandom_range(0, 7));
      r  = 1'b0;
      w  = 1'b0;
      if ($urandom_range(0, 9) >= 3) begin
        r = 1'($urandom_range(0, 1));
        w = r ? ($urandom_range(0, 3) == 0) : 1'b1;
        if ($urandom_range(0, 3) != 0) f3 = r ? 3'($urandom_range(0, 1) * 4 + $urandom_range(0, 1))
                                               : 3'($urandom_range(0, 2));
        if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      end
      do_op(a, $urandom, f3, r, w, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
